// File: rtl/clint_bus_if.sv
// rtl/clint_bus_if.sv - data-bus bundle between the load/store unit and the CLINT
//
// Purpose: groups the word-oriented data bus seen by the core-local interruptor.
// Signals:
//   bus_select        chip-select from the interconnect
//   bus_address       byte address (bits [15:2] decoded by the responder)
//   bus_write_data    lane-replicated store data
//   bus_byte_enable   per-lane write mask, bit i covers [8i+7:8i]
//   bus_write_enable  write strobe
//   bus_read_enable   read strobe
//   bus_read_data     combinational read word from the responder
// Modports: master (load/store unit side), slave (CLINT side).

interface clint_bus_if;
   logic        bus_select;
   logic [31:0] bus_address;
   logic [31:0] bus_write_data;
   logic [3:0]  bus_byte_enable;
   logic        bus_write_enable;
   logic        bus_read_enable;
   logic [31:0] bus_read_data;

   modport master (
      output bus_select, bus_address, bus_write_data, bus_byte_enable,
             bus_write_enable, bus_read_enable,
      input  bus_read_data
   );

   modport slave (
      input  bus_select, bus_address, bus_write_data, bus_byte_enable,
             bus_write_enable, bus_read_enable,
      output bus_read_data
   );
endinterface

// File: rtl/clint_responder.sv
// rtl/clint_responder.sv - core-local interruptor: mtime, mtimecmp, msip and IRQ lines
//
// Purpose: memory-mapped responder holding the shared 64-bit mtime counter, a
// per-hart 64-bit mtimecmp and a per-hart msip bit.
// Ports:
//   clk                 core clock
//   rst_n               asynchronous active-low reset
//   bus                 clint_bus_if.slave data bus (zero-wait, combinational read)
//   timer_interrupt     per-hart MTIP, registered (mtime >= mtimecmp[h])
//   software_interrupt  per-hart MSIP, straight from msip[h]
// Word map (offset[15:2]): msip[h] = h, mtimecmp[h] lo/hi = 0x1000+2h / +1,
// mtime lo/hi = 0x2FFE / 0x2FFF.

module clint_responder #(
   parameter int NUM_HARTS = 2,
   parameter int TICK_DIV  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   clint_bus_if.slave           bus,
   output logic [NUM_HARTS-1:0] timer_interrupt,
   output logic [NUM_HARTS-1:0] software_interrupt
);

   localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [13:0]     MTIME_LO_W = 14'h2FFE;
   localparam logic [13:0]     MTIME_HI_W = 14'h2FFF;
   localparam logic [13:0]     CMP_BASE_W = 14'h1000;

   logic [TW-1:0]        tick_cnt;
   logic                 tick;
   logic [63:0]          mtime;
   logic [63:0]          mtime_next;
   logic [63:0]          mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip;

   logic [13:0]          word_idx;
   logic                 wr_en;
   logic                 rd_en;
   logic                 wr_mtime_lo;
   logic                 wr_mtime_hi;
   logic [NUM_HARTS-1:0] wr_msip;
   logic [NUM_HARTS-1:0] wr_cmp_lo;
   logic [NUM_HARTS-1:0] wr_cmp_hi;
   logic [31:0]          read_word;
   logic                 unused_addr_bits;

   // Byte-lane merge: lanes with a clear enable keep the old contents.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
      logic [31:0] r;
      r = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
      end
      return r;
   endfunction

   assign word_idx         = bus.bus_address[15:2];
   assign unused_addr_bits = ^{bus.bus_address[31:16], bus.bus_address[1:0]};

   // An all-zero byte-enable is treated as no write at all, so it never
   // suppresses the mtime increment.
   assign wr_en       = bus.bus_select & bus.bus_write_enable & (|bus.bus_byte_enable);
   assign rd_en       = bus.bus_select & bus.bus_read_enable;
   assign wr_mtime_lo = wr_en & (word_idx == MTIME_LO_W);
   assign wr_mtime_hi = wr_en & (word_idx == MTIME_HI_W);

   always_comb begin
      wr_msip   = '0;
      wr_cmp_lo = '0;
      wr_cmp_hi = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         wr_msip[h]   = wr_en & (word_idx == 14'(h));
         wr_cmp_lo[h] = wr_en & (word_idx == (CMP_BASE_W + 14'(2 * h)));
         wr_cmp_hi[h] = wr_en & (word_idx == (CMP_BASE_W + 14'(2 * h + 1)));
      end
   end

   // Prescaler
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
   end

   // A bus write to either mtime word wins over the tick in that cycle.
   always_comb begin
      mtime_next = mtime;
      if (wr_mtime_lo || wr_mtime_hi) begin
         if (wr_mtime_lo)
            mtime_next[31:0]  = merge_lanes(mtime[31:0], bus.bus_write_data, bus.bus_byte_enable);
         if (wr_mtime_hi)
            mtime_next[63:32] = merge_lanes(mtime[63:32], bus.bus_write_data, bus.bus_byte_enable);
      end else if (tick) begin
         mtime_next = mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime <= '0;
      end else begin
         mtime <= mtime_next;
      end
   end

   // Per-hart registers; the compare uses current register values, so a
   // register write reaches timer_interrupt one edge after it lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
         msip            <= '0;
         timer_interrupt <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (wr_cmp_lo[h])
               mtimecmp[h][31:0]  <= merge_lanes(mtimecmp[h][31:0], bus.bus_write_data,
                                                 bus.bus_byte_enable);
            if (wr_cmp_hi[h])
               mtimecmp[h][63:32] <= merge_lanes(mtimecmp[h][63:32], bus.bus_write_data,
                                                 bus.bus_byte_enable);
            if (wr_msip[h] && bus.bus_byte_enable[0])
               msip[h] <= bus.bus_write_data[0];
            timer_interrupt[h] <= (mtime >= mtimecmp[h]);
         end
      end
   end

   assign software_interrupt = msip;

   // Read mux: pre-write register values, full words, zero when not strobed.
   always_comb begin
      read_word = '0;
      if (rd_en) begin
         if (word_idx == MTIME_LO_W) read_word = mtime[31:0];
         if (word_idx == MTIME_HI_W) read_word = mtime[63:32];
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (word_idx == 14'(h))                        read_word = {31'b0, msip[h]};
            if (word_idx == (CMP_BASE_W + 14'(2 * h)))     read_word = mtimecmp[h][31:0];
            if (word_idx == (CMP_BASE_W + 14'(2 * h + 1))) read_word = mtimecmp[h][63:32];
         end
      end
   end

   assign bus.bus_read_data = read_word;

endmodule

// File: tb/tb_clint_responder.sv
// tb/tb_clint_responder.sv - self-checking bench for clint_responder

module tb_clint_responder;
   localparam int NUM_HARTS = 2;
   localparam int TICK_DIV  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clint_bus_if bus();
   logic [NUM_HARTS-1:0] timer_interrupt;
   logic [NUM_HARTS-1:0] software_interrupt;

   clint_responder #(.NUM_HARTS(NUM_HARTS), .TICK_DIV(TICK_DIV)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bus                (bus),
      .timer_interrupt    (timer_interrupt),
      .software_interrupt (software_interrupt)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   longint unsigned      m_cycles;
   logic [63:0]          m_mtime;
   logic [63:0]          m_cmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] m_msip;
   logic [NUM_HARTS-1:0] m_tip;

   function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic int unsigned offset_of(input logic [31:0] addr);
      return {16'h0, addr[15:0]} & 32'h0000_FFFC;
   endfunction

   function automatic bit m_writing();
      return bus.bus_select && bus.bus_write_enable && (bus.bus_byte_enable != 4'b0);
   endfunction

   function automatic logic [63:0] next_mtime();
      int unsigned off;
      logic [63:0] v;
      off = offset_of(bus.bus_address);
      v   = m_mtime;
      if (m_writing() && (off == 32'hBFF8 || off == 32'hBFFC)) begin
         if (off == 32'hBFF8) v[31:0]  = lane_merge(v[31:0], bus.bus_write_data, bus.bus_byte_enable);
         else                 v[63:32] = lane_merge(v[63:32], bus.bus_write_data, bus.bus_byte_enable);
         return v;
      end
      if ((m_cycles % TICK_DIV) == TICK_DIV - 1) return m_mtime + 64'd1;
      return m_mtime;
   endfunction

   function automatic logic [63:0] next_cmp(input int h);
      int unsigned off;
      logic [63:0] v;
      off = offset_of(bus.bus_address);
      v   = m_cmp[h];
      if (m_writing()) begin
         if (off == 32'h4000 + 8 * h)
            v[31:0]  = lane_merge(v[31:0], bus.bus_write_data, bus.bus_byte_enable);
         if (off == 32'h4004 + 8 * h)
            v[63:32] = lane_merge(v[63:32], bus.bus_write_data, bus.bus_byte_enable);
      end
      return v;
   endfunction

   function automatic logic next_msip(input int h);
      if (m_writing() && offset_of(bus.bus_address) == 4 * h && bus.bus_byte_enable[0])
         return bus.bus_write_data[0];
      return m_msip[h];
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] addr);
      int unsigned off;
      int unsigned h;
      off = offset_of(addr);
      if (off < 4 * NUM_HARTS) return {31'b0, m_msip[off / 4]};
      if (off >= 32'h4000 && off < 32'h4000 + 8 * NUM_HARTS) begin
         h = (off - 32'h4000) / 8;
         return ((off % 8) == 0) ? m_cmp[h][31:0] : m_cmp[h][63:32];
      end
      if (off == 32'hBFF8) return m_mtime[31:0];
      if (off == 32'hBFFC) return m_mtime[63:32];
      return 32'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cycles <= 0;
         m_mtime  <= '0;
         for (int h = 0; h < NUM_HARTS; h++) m_cmp[h] <= '1;
         m_msip   <= '0;
         m_tip    <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            m_tip[h]  <= (m_mtime >= m_cmp[h]);
            m_cmp[h]  <= next_cmp(h);
            m_msip[h] <= next_msip(h);
         end
         m_mtime  <= next_mtime();
         m_cycles <= m_cycles + 1;
      end
   end

   // ---------------- bus driving ----------------
   task automatic drive(input logic sel, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic we, input logic re);
      bus.bus_select       = sel;
      bus.bus_address      = addr;
      bus.bus_write_data   = wd;
      bus.bus_byte_enable  = be;
      bus.bus_write_enable = we;
      bus.bus_read_enable  = re;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic step_idle();
      @(negedge clk);
      idle();
      #1;
   endtask

   // Drives one access in the current cycle (no wait) and samples read data.
   task automatic cycle_now(input logic sel, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic we, input logic re,
                            output logic [31:0] rd, output logic [31:0] ex);
      drive(sel, addr, wd, be, we, re);
      #1;
      rd = bus.bus_read_data;
      ex = (sel && re) ? exp_read(addr) : 32'h0;
   endtask

   task automatic cycle(input logic sel, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic we, input logic re,
                        output logic [31:0] rd, output logic [31:0] ex);
      @(negedge clk);
      cycle_now(sel, addr, wd, be, we, re, rd, ex);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] rd, ex;
      cycle(1'b1, addr, wd, be, 1'b1, 1'b0, rd, ex);
   endtask

   task automatic rd_word(input logic [31:0] addr, output logic [31:0] rd, output logic [31:0] ex);
      cycle(1'b1, addr, 32'h0, 4'h0, 1'b0, 1'b1, rd, ex);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] rd, ex;
      idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr(32'h0000, 32'h1, 4'hF);
      repeat (6) step_idle();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      drive(1'b1, 32'hBFF8, 32'h0, 4'h0, 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.bus_read_data !== 32'h0) begin
         errors++; $display("FAIL reset_read_data: got %h expected %h", bus.bus_read_data, 32'h0);
      end
      checks++;
      if (timer_interrupt !== '0 || software_interrupt !== '0) begin
         errors++; $display("FAIL reset_irqs: got %b/%b expected 00/00", timer_interrupt, software_interrupt);
      end
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= TICK_DIV; i++) begin
         rd_word(32'hBFF8, rd, ex);
         checks++;
         if (rd !== ((i == TICK_DIV) ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL reset_first_tick[%0d]: got %h expected %h", i, rd, (i == TICK_DIV) ? 1 : 0);
         end
      end
      rd_word(32'h4000, rd, ex);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL reset_cmp0_lo: got %h expected ffffffff", rd);
      end
      rd_word(32'h4004, rd, ex);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL reset_cmp0_hi: got %h expected ffffffff", rd);
      end
      rd_word(32'hBFFC, rd, ex);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL reset_mtime_hi: got %h expected 0", rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, ex;
      wr(32'h4008, 32'hAABB_CCDD, 4'b0100);
      rd_word(32'h4008, rd, ex);
      checks++;
      if (rd !== 32'hFFBB_FFFF || rd !== ex) begin
         errors++; $display("FAIL byte_lane_write: got %h expected ffbbffff (model %h)", rd, ex);
      end
      wr(32'h4008, 32'h1234_5678, 4'b0000);
      rd_word(32'h4008, rd, ex);
      checks++;
      if (rd !== 32'hFFBB_FFFF) begin
         errors++; $display("FAIL byte_lane_zero_be: got %h expected ffbbffff", rd);
      end
   endtask

   task automatic test_timer_irq();
      logic [31:0] rd, ex;
      bit seen10 = 0;
      bit done   = 0;
      wr(32'hBFFC, 32'h0, 4'hF);
      wr(32'hBFF8, 32'h0, 4'hF);
      wr(32'h4000, 32'd10, 4'hF);
      wr(32'h4004, 32'h0, 4'hF);
      for (int i = 0; i < 80 && !done; i++) begin
         rd_word(32'hBFF8, rd, ex);
         checks++;
         if (timer_interrupt[1] !== 1'b0) begin
            errors++; $display("FAIL timer_irq_hart1: got %b expected 0", timer_interrupt[1]);
         end
         if (seen10) begin
            checks++;
            if (timer_interrupt[0] !== 1'b1) begin
               errors++; $display("FAIL timer_irq_rise: got %b expected 1", timer_interrupt[0]);
            end
            done = 1;
         end else if (rd == 32'd10) begin
            checks++;
            if (timer_interrupt[0] !== 1'b0) begin
               errors++; $display("FAIL timer_irq_early: got %b expected 0", timer_interrupt[0]);
            end
            seen10 = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL timer_irq_timeout: got no rise expected rise within 80 cycles");
      end
      wr(32'h4004, 32'h1, 4'hF);
      step_idle();
      checks++;
      if (timer_interrupt[0] !== 1'b1) begin
         errors++; $display("FAIL timer_irq_hold: got %b expected 1", timer_interrupt[0]);
      end
      step_idle();
      checks++;
      if (timer_interrupt[0] !== 1'b0) begin
         errors++; $display("FAIL timer_irq_fall: got %b expected 0", timer_interrupt[0]);
      end
   endtask

   task automatic test_carry_and_priority();
      logic [31:0] rd, ex;
      bit done = 0;
      wr(32'hBFFC, 32'h0, 4'hF);
      wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 3 * TICK_DIV && !done; i++) begin
         rd_word(32'hBFF8, rd, ex);
         if (rd !== 32'hFFFF_FFFF) begin
            checks++;
            if (rd !== 32'h0) begin
               errors++; $display("FAIL carry_lo: got %h expected 0", rd);
            end
            rd_word(32'hBFFC, rd, ex);
            checks++;
            if (rd !== 32'h1) begin
               errors++; $display("FAIL carry_hi: got %h expected 1", rd);
            end
            done = 1;
         end
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL carry_timeout: got no tick expected tick within %0d cycles", 3 * TICK_DIV);
      end
      // Align so the write lands on an edge where the prescaler ticks.
      done = 0;
      for (int i = 0; i < 2 * TICK_DIV && !done; i++) begin
         step_idle();
         if ((m_cycles % TICK_DIV) == TICK_DIV - 1) done = 1;
      end
      cycle_now(1'b1, 32'hBFF8, 32'h0000_0055, 4'hF, 1'b1, 1'b0, rd, ex);
      rd_word(32'hBFF8, rd, ex);
      checks++;
      if (rd !== 32'h0000_0055) begin
         errors++; $display("FAIL write_on_tick_lo: got %h expected 00000055", rd);
      end
      rd_word(32'hBFFC, rd, ex);
      checks++;
      if (rd !== 32'h1) begin
         errors++; $display("FAIL write_on_tick_hi: got %h expected 1", rd);
      end
   endtask

   task automatic test_software_irq();
      logic [31:0] rd, ex;
      cycle(1'b1, 32'h0004, 32'h1, 4'hF, 1'b1, 1'b1, rd, ex);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL msip_read_pre_write: got %h expected 0", rd);
      end
      step_idle();
      checks++;
      if (software_interrupt !== 2'b10) begin
         errors++; $display("FAIL msip_irq: got %b expected 10", software_interrupt);
      end
      rd_word(32'h0100, rd, ex);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL unmapped_0100: got %h expected 0", rd);
      end
      wr(32'h0008, 32'h1, 4'hF);
      rd_word(32'h0008, rd, ex);
      checks++;
      if (rd !== 32'h0 || software_interrupt !== 2'b10) begin
         errors++; $display("FAIL absent_hart2: got %h/%b expected 0/10", rd, software_interrupt);
      end
   endtask

   task automatic test_deselect();
      logic [31:0] rd, ex;
      cycle(1'b0, 32'hBFF8, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, rd, ex);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL deselect_read: got %h expected 0", rd);
      end
      rd_word(32'hBFF8, rd, ex);
      checks++;
      if (rd === 32'hDEAD_BEEF || rd !== ex) begin
         errors++; $display("FAIL deselect_mtime: got %h expected %h", rd, ex);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, ex, addr;
      logic [15:0] offs [12];
      logic        sel, we, re;
      offs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
               16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h0100, 16'h0000};
      for (int i = 0; i < 400; i++) begin
         addr = offs[$urandom_range(0, 11)];
         if (i % 11 == 10) addr = {16'h0, 16'($urandom())};
         addr = addr | ($urandom() & 32'hFFFF_0000) | ($urandom() & 32'h3);
         sel  = ($urandom_range(0, 7) != 0);
         we   = $urandom_range(0, 2) == 0;
         re   = $urandom_range(0, 1) == 1;
         cycle(sel, addr, $urandom(), 4'($urandom_range(0, 15)), we, re, rd, ex);
         checks++;
         if (rd !== ex) begin
            errors++; $display("FAIL random_read[%0d] addr %h: got %h expected %h", i, addr, rd, ex);
         end
         checks++;
         if (timer_interrupt !== m_tip || software_interrupt !== m_msip) begin
            errors++; $display("FAIL random_irqs[%0d]: got %b/%b expected %b/%b",
                               i, timer_interrupt, software_interrupt, m_tip, m_msip);
         end
      end
      step_idle();
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_timer_irq();
      test_carry_and_priority();
      test_software_irq();
      test_deselect();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1);
   end

endmodule
